regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file among NUM_REQ write-back sources (e.g. ALU result, load data, multi-cycle unit).
- Uses valid/ready handshakes, round-robin arbitration and a registered output stage.
- Drives the register file's reg_write, write_reg and write_data directly.
- Sits between the execute/memory write-back sources and the register file.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8)
- ADDR_W, 5, register index width
- DATA_W, 32, write data width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_ready  output  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both high
- req_addr  input  NUM_REQ*ADDR_W  packed destination indices; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
- wr_inhibit  input  1  freezes arbitration (no grants) while high
- reg_write  output  1  register file write enable
- write_reg  output  ADDR_W  register file write index
- write_data  output  DATA_W  register file write data
- grant_id  output  $clog2(NUM_REQ)  index of the requester whose write is on the port this cycle
- busy  output  1  high when any req_valid is high or reg_write is high

Behaviour:
- Reset (rst sampled high at posedge clk):
  - reg_write=0, write_reg=0, write_data=0, grant_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is all zeros during the reset cycle.
- Arbitration (combinational, each cycle):
  - Search from rr_ptr upward, modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - req_ready is one-hot on the winner; all zeros if there is no valid request or wr_inhibit=1.
  - req_ready depends only on req_valid, rr_ptr, wr_inhibit and rst, never on req_addr or req_data.
- Pointer update:
  - On a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - A requester held continuously valid is served within NUM_REQ grants.
- Output stage, registered:
  - The cycle after a grant to i: write_reg=req_addr[i], write_data=req_data[i], grant_id=i.
  - reg_write=1 in that same cycle unless req_addr[i]==0.
  - Latency from handshake edge to reg_write high is exactly 1 cycle.
  - reg_write is high for one cycle per transfer.
  - The output stage never stalls, so back-to-back grants produce back-to-back writes at full throughput.
- Register 0:
  - A request to index 0 is accepted normally and consumes its round-robin turn.
  - reg_write stays 0 for it, because x0 is hardwired zero.
  - write_reg, write_data and grant_id still update.
- Idle cycle: reg_write=0; write_reg, write_data and grant_id hold their last values.
- wr_inhibit:
  - While high: no grants, rr_ptr holds, and an already-registered write completes.
  - Deassertion takes effect the same cycle.
- Simultaneous requests to the same destination are serialized in grant order; the later grant's data is the final register value.
- Requesters must hold addr and data stable while valid and not ready. Dropping valid before ready is permitted; the block keeps no record of it.
- rst mid-transfer: the in-flight registered write is cancelled (reg_write=0 next cycle) and rr_ptr returns to 0.
- Read ports of the register file are not arbitrated by this block.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0
  - function clog2_safe (returns 1 for NUM_REQ<=2)
- One sub-module, rr_arbiter:
  - Generic NUM_REQ round-robin grant with pointer and an enable input (driven by ~wr_inhibit).
  - Outputs one-hot grant and encoded index.
- Top level adds the mux, the x0 filter and the output register.

Test Plan:
- Reset, then req_valid=3'b001, addr 8, data 32'h0000_0005 → req_ready=001 same cycle; next cycle reg_write=1, write_reg=8, write_data=5, grant_id=0.
- req_valid=3'b111 held 6 cycles, rr_ptr=0, addrs 1/2/3 → grants in order 0,1,2,0,1,2; six consecutive reg_write pulses with matching write_reg.
- req_valid=3'b010, addr 0, data 32'hDEAD_BEEF → req_ready=010 accepted; next cycle reg_write=0, grant_id=1, write_data=DEAD_BEEF.
- wr_inhibit=1 for 3 cycles with req_valid=3'b100 → req_ready=000 throughout; first cycle after release: req_ready=100, write follows 1 cycle later.
- Requesters 0 and 2 both target reg 25 with data 7 and 9, rr_ptr=0 → writes occur in order 7 then 9; reading reg 25 afterwards returns 9.
- rst asserted the cycle after a grant → reg_write=0, rr_ptr=0, req_ready=000 during rst; a subsequent 3'b111 request grants requester 0 first.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_ADDR_W / REG_DATA_W : default register index / data widths
//   REG_ZERO                : index of the hardwired-zero register x0
//   clog2_safe()            : index width that never collapses to zero bits
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Width of an encoded requester index; at least one bit even for n <= 2.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the write-back requesters and the register-file write port.
//   req_valid/req_ready : per-requester handshake
//   req_addr/req_data   : packed per-requester index/data (requester i at slot i)
//   wr_inhibit          : freezes arbitration while high
//   reg_write/write_reg/write_data : register-file write port
//   grant_id            : requester whose write is on the port
//   busy                : any request pending or a write on the port
// master = requester/register-file side, slave = arbiter side.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) ();

    localparam int ID_W = clog2_safe(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      wr_inhibit;
    logic                      reg_write;
    logic [ADDR_W-1:0]         write_reg;
    logic [DATA_W-1:0]         write_data;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport master (
        output req_valid, req_addr, req_data, wr_inhibit,
        input  req_ready, reg_write, write_reg, write_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, wr_inhibit,
        output req_ready, reg_write, write_reg, write_data, grant_id, busy
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Generic round-robin arbiter with a rotating priority pointer.
//   clk, rst    : clock, synchronous active-high reset (pointer -> 0, no grant)
//   en          : grants allowed when high; pointer holds when low
//   req         : request vector
//   grant       : one-hot grant (all zeros when nothing granted)
//   grant_idx   : encoded index of the granted request
//   grant_valid : a grant is issued this cycle
module regfile_write_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0] ptr;

    // Scan from ptr upward with wrap; the first active request wins.
    always_comb begin
        int unsigned     j;
        logic [ID_W-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = ID_W'(j);
            if (!grant_valid && en && !rst && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ write-back sources.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of regfile_write_arbiter_if (handshakes, packed
//              request index/data, wr_inhibit, register-file write port,
//              grant_id, busy)
// Combinational round-robin grant, registered write stage one cycle later.
// Writes to x0 are accepted but never raise reg_write.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam int ID_W = clog2_safe(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               we_q;
    logic [ADDR_W-1:0]  reg_q;
    logic [DATA_W-1:0]  data_q;
    logic [ID_W-1:0]    id_q;

    regfile_write_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (~bus.wr_inhibit),
        .req         (bus.req_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        if (grant_valid) begin
            sel_addr = addr_arr[grant_idx];
            sel_data = data_arr[grant_idx];
        end
    end

    // Output stage never stalls: each grant lands on the port the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            we_q <= grant_valid && (sel_addr != ADDR_W'(REG_ZERO));
            if (grant_valid) begin
                reg_q  <= sel_addr;
                data_q <= sel_data;
                id_q   <= grant_idx;
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.reg_write  = we_q;
    assign bus.write_reg  = reg_q;
    assign bus.write_data = data_q;
    assign bus.grant_id   = id_q;
    assign bus.busy       = (|bus.req_valid) | we_q;

endmodule
